line_buffer_nrow: RTL and testbench

Parametrised line buffer for streaming raster images. It delivers a vertical column of `ROWS` vertically adjacent pixels per accepted input pixel, which is what the 3x3 (and larger) kernels of the edge-detection pipeline need. Row count, maximum line length and pixel width are set by parameters; the active line width is set per frame at run time. Top-of-frame border handling is built in, so downstream window logic receives defined data from the first row of every frame.

---
 rtl/img_pkg.sv | 16 +
 rtl/line_buffer_nrow_line_ram.sv | 30 +++
 rtl/line_buffer_nrow.sv | 167 ++++++++++++++++
 tb/tb_line_buffer_nrow.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image line-buffer blocks: border modes,
// pixel type and a counter-width helper.
package img_pkg;

    localparam int BORDER_ZERO      = 0;
    localparam int BORDER_REPLICATE = 1;

    localparam int PIX_W = 8;
    typedef logic [PIX_W-1:0] pixel_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer_nrow_line_ram.sv
// Simple dual-port line memory: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module line_ram
    import img_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_WIDTH = cnt_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buffer_nrow.sv
// N-row line buffer: emits a column of ROWS vertically adjacent pixels per
// accepted pixel, with top-of-frame border masking.
module line_buffer_nrow
    import img_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_LINE    = 640,
    parameter int ROWS        = 3,
    parameter int BORDER_MODE = BORDER_ZERO
) (
    input  logic                            clock,
    input  logic                            rst_n,
    input  logic                            sof,
    input  logic [$clog2(MAX_LINE+1)-1:0]   line_width,
    input  logic                            clken,
    input  logic [DATA_WIDTH-1:0]           shiftin,
    output logic [ROWS*DATA_WIDTH-1:0]      taps,
    output logic                            taps_valid,
    output logic [$clog2(ROWS+1)-1:0]       rows_filled
);

    localparam int LW_W = $clog2(MAX_LINE + 1);
    localparam int AW   = cnt_width(MAX_LINE);
    localparam int RW   = cnt_width(ROWS);
    localparam int RFW  = $clog2(ROWS + 1);
    localparam int NMEM = ROWS - 1;

    // Handshake: clken qualifies shiftin and sof; there is no ready, so every
    // clken cycle is accepted, and taps_valid is high for exactly one cycle,
    // one cycle after each accepted pixel. taps/rows_filled hold otherwise.

    logic [LW_W-1:0]       col_q;
    logic [RW-1:0]         row_q;
    logic [LW_W-1:0]       lw_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [RFW-1:0]        rows_filled_q;
    logic                  taps_valid_q;

    logic                  wr_pend_q;
    logic [AW-1:0]         wa_q;
    logic                  fwd_q;
    logic [DATA_WIDTH-1:0] fwd_d [NMEM];

    logic [DATA_WIDTH-1:0] mem_out [NMEM];
    logic [DATA_WIDTH-1:0] wdata   [NMEM];
    logic [DATA_WIDTH-1:0] raw     [ROWS];
    logic [DATA_WIDTH-1:0] repl;

    logic [LW_W-1:0] lw_clamped;
    logic [LW_W-1:0] cur_lw;
    logic [LW_W-1:0] cur_col;
    logic [RW-1:0]   cur_row;
    logic [AW-1:0]   cur_addr;
    logic            wrap;
    logic [LW_W-1:0] nxt_col;
    logic [RW-1:0]   nxt_row;

    // A sof pixel is column 0, row 0 of a line of the newly sampled width.
    always_comb begin
        lw_clamped = line_width;
        if (line_width == '0 || line_width > LW_W'(MAX_LINE)) begin
            lw_clamped = LW_W'(MAX_LINE);
        end
        cur_lw   = sof ? lw_clamped : lw_q;
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        cur_addr = cur_col[AW-1:0];
        wrap     = (cur_col == cur_lw - LW_W'(1));
        nxt_col  = wrap ? '0 : cur_col + LW_W'(1);
        nxt_row  = cur_row;
        if (wrap && cur_row != RW'(ROWS - 1)) begin
            nxt_row = cur_row + RW'(1);
        end
    end

    // Memory k holds the line k+1 rows above. Its write lands one cycle after
    // the read it cascades from; a read of that same address in that cycle is
    // served from fwd_d instead of the not-yet-updated memory.
    for (genvar k = 0; k < NMEM; k++) begin : g_line
        logic [DATA_WIDTH-1:0] rdata;

        line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_LINE),
            .ADDR_WIDTH (AW)
        ) u_ram (
            .clock (clock),
            .we    (wr_pend_q),
            .waddr (wa_q),
            .wdata (wdata[k]),
            .re    (clken),
            .raddr (cur_addr),
            .rdata (rdata)
        );

        assign mem_out[k] = fwd_q ? fwd_d[k] : rdata;

        if (k == 0) begin : g_head
            assign wdata[k] = pix_q;
        end else begin : g_tail
            assign wdata[k] = mem_out[k-1];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            lw_q          <= LW_W'(MAX_LINE);
            pix_q         <= '0;
            rows_filled_q <= '0;
            taps_valid_q  <= 1'b0;
            wr_pend_q     <= 1'b0;
            wa_q          <= '0;
            fwd_q         <= 1'b0;
            for (int k = 0; k < NMEM; k++) begin
                fwd_d[k] <= '0;
            end
        end else begin
            taps_valid_q <= clken;
            wr_pend_q    <= clken;
            if (sof) begin
                lw_q <= lw_clamped;
            end
            if (clken) begin
                pix_q         <= shiftin;
                rows_filled_q <= RFW'(cur_row) + RFW'(1);
                wa_q          <= cur_addr;
                fwd_q         <= wr_pend_q && (wa_q == cur_addr);
                for (int k = 0; k < NMEM; k++) begin
                    fwd_d[k] <= wdata[k];
                end
                col_q <= nxt_col;
                row_q <= nxt_row;
            end else if (sof) begin
                col_q <= '0;
                row_q <= '0;
            end
        end
    end

    // Rows not yet filled in this frame are zeroed or copy the oldest filled row.
    always_comb begin
        raw[0] = pix_q;
        for (int k = 0; k < NMEM; k++) begin
            raw[k+1] = mem_out[k];
        end
        repl = raw[0];
        for (int k = 0; k < ROWS; k++) begin
            if (k == int'(rows_filled_q) - 1) begin
                repl = raw[k];
            end
        end
        taps = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (k < int'(rows_filled_q)) begin
                taps[k*DATA_WIDTH +: DATA_WIDTH] = raw[k];
            end else if (BORDER_MODE == BORDER_REPLICATE && rows_filled_q != '0) begin
                taps[k*DATA_WIDTH +: DATA_WIDTH] = repl;
            end
        end
    end

    assign taps_valid  = taps_valid_q;
    assign rows_filled = rows_filled_q;

endmodule

// File: tb/tb_line_buffer_nrow.sv
// Directed bench for line_buffer_nrow: zero-border and replicate-border
// instances driven side by side, checked against a frame-coordinate model.
module tb_line_buffer_nrow;
    import img_pkg::*;

    localparam int DW  = 8;
    localparam int ML  = 640;
    localparam int NR  = 3;
    localparam int LWW = $clog2(ML + 1);
    localparam int TW  = NR * DW;
    localparam int RFW = $clog2(NR + 1);

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic           sof = 1'b0;
    logic           clken = 1'b0;
    logic [LWW-1:0] line_width = '0;
    logic [DW-1:0]  shiftin = '0;

    logic [TW-1:0]  taps0, taps1;
    logic           tv0, tv1;
    logic [RFW-1:0] rf0, rf1;

    line_buffer_nrow #(.DATA_WIDTH(DW), .MAX_LINE(ML), .ROWS(NR), .BORDER_MODE(BORDER_ZERO)) dut0 (
        .clock(clock), .rst_n(rst_n), .sof(sof), .line_width(line_width), .clken(clken),
        .shiftin(shiftin), .taps(taps0), .taps_valid(tv0), .rows_filled(rf0)
    );

    line_buffer_nrow #(.DATA_WIDTH(DW), .MAX_LINE(ML), .ROWS(NR), .BORDER_MODE(BORDER_REPLICATE)) dut1 (
        .clock(clock), .rst_n(rst_n), .sof(sof), .line_width(line_width), .clken(clken),
        .shiftin(shiftin), .taps(taps1), .taps_valid(tv1), .rows_filled(rf1)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [TW+RFW-1:0] exp0_q[$];
    logic [TW+RFW-1:0] exp1_q[$];
    logic [TW-1:0] last0 = '0;
    logic [TW-1:0] last1 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-coordinate model: pixel value depends only on (row, col) of the frame.
    int m_col = 0;
    int m_row = 0;
    int m_lw  = ML;
    int m_base = 0;

    function automatic logic [DW-1:0] pix_of(input int r, input int c);
        return DW'(m_base + 16 * r + c);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic s, input int lw_in);
        logic [DW-1:0]     px;
        logic [TW-1:0]     e0, e1;
        logic [TW+RFW-1:0] ex;
        int rf;
        px = '0;
        e0 = '0;
        e1 = '0;
        if (s) begin
            m_lw  = (lw_in == 0 || lw_in > ML) ? ML : lw_in;
            m_col = 0;
            m_row = 0;
        end
        if (en) begin
            px = pix_of(m_row, m_col);
            for (int k = 0; k < NR; k++) begin
                if (k <= m_row) begin
                    e0[k*DW +: DW] = pix_of(m_row - k, m_col);
                    e1[k*DW +: DW] = pix_of(m_row - k, m_col);
                end else begin
                    e0[k*DW +: DW] = '0;
                    e1[k*DW +: DW] = pix_of(0, m_col);
                end
            end
            rf = (m_row + 1 > NR) ? NR : m_row + 1;
            exp0_q.push_back({e0, RFW'(rf)});
            exp1_q.push_back({e1, RFW'(rf)});
            if (m_col == m_lw - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
        clken      = en;
        sof        = s;
        line_width = LWW'(lw_in);
        shiftin    = px;
        @(posedge clock);
        #1;
        clken = 1'b0;
        sof   = 1'b0;
        check("valid0", tv0, en);
        check("valid1", tv1, en);
        if (en) begin
            ex = exp0_q.pop_front();
            check("taps0", taps0, ex[TW+RFW-1:RFW]);
            check("rows_filled0", rf0, ex[RFW-1:0]);
            last0 = ex[TW+RFW-1:RFW];
            ex = exp1_q.pop_front();
            check("taps1", taps1, ex[TW+RFW-1:RFW]);
            check("rows_filled1", rf1, ex[RFW-1:0]);
            last1 = ex[TW+RFW-1:RFW];
        end else begin
            check("hold0", taps0, last0);
            check("hold1", taps1, last1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps [3];
        gaps = '{0, 1, 5};

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_taps0", taps0, 0);
        check("rst_valid0", tv0, 0);
        check("rst_rf0", rf0, 0);
        check("rst_taps1", taps1, 0);
        check("rst_valid1", tv1, 0);
        check("rst_rf1", rf1, 0);
        rst_n = 1'b1;

        // Ramp frame, width 4, three lines
        m_base = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, (r == 0 && c == 0), 4);
                if (r == 0 && c == 2) begin
                    check("ramp_r0c2_zero", taps0, 24'h000002);
                    check("ramp_r0c2_repl", taps1, 24'h020202);
                    check("ramp_r0c2_rf", rf0, 1);
                end
                if (r == 2 && c == 1) begin
                    check("ramp_r2c1", taps0, 24'h011121);
                    check("ramp_r2c1_rf", rf0, 3);
                end
            end
        end

        // Same frame shape with clken gaps of 0, 1 and 5 cycles
        m_base = 8'h40;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i == 0), 4);
            for (int g = 0; g < gaps[i % 3]; g++) begin
                drive(1'b0, 1'b0, 4);
            end
        end

        // sof without clken, then a mid-line sof with width change 4 -> 6
        m_base = 8'h80;
        drive(1'b0, 1'b1, 4);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 4);
        end
        m_base = 8'hA0;
        drive(1'b1, 1'b1, 6);
        check("midsof_rf", rf0, 1);
        check("midsof_taps", taps0, 24'h0000A0);
        for (int j = 1; j < 8; j++) begin
            drive(1'b1, 1'b0, 6);
            if (j == 5) check("w6_last_col_rf", rf0, 1);
            if (j == 6) begin
                check("w6_wrap_rf", rf0, 2);
                check("w6_wrap_taps", taps0, 24'h00A0B0);
            end
        end
        // now row 1 col 2; finish row then sof lands on the wrap cycle
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 6);
        end
        m_base = 8'h20;
        drive(1'b1, 1'b1, 4);
        check("sof_on_wrap_rf", rf0, 1);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 4);
        end
        check("sof_on_wrap_next_rf", rf0, 2);

        // Width 1: every pixel starts a new line
        m_base = 8'h30;
        drive(1'b1, 1'b1, 1);
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 1);
        end
        check("w1_taps", taps0, 24'h405060);
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b0, 1);

        // Width 0 and width 1000 both clamp to 640
        m_base = 8'h07;
        drive(1'b1, 1'b1, 0);
        for (int j = 1; j < 641; j++) begin
            drive(1'b1, 1'b0, 0);
            if (j == 639) check("w0_col639_rf", rf0, 1);
        end
        check("w0_wrap_rf", rf0, 2);
        check("w0_wrap_taps", taps0, 24'h000717);
        m_base = 8'h0B;
        drive(1'b1, 1'b1, 1000);
        for (int j = 1; j < 641; j++) begin
            drive(1'b1, 1'b0, 1000);
        end
        check("w1000_wrap_rf", rf0, 2);
        check("w1000_wrap_taps", taps0, 24'h000B1B);

        // Asynchronous reset during line 2
        m_base = 8'h50;
        for (int j = 0; j < 9; j++) begin
            drive(1'b1, (j == 0), 4);
        end
        check("pre_rst_rf", rf0, 3);
        rst_n = 1'b0;
        #2;
        check("arst_taps0", taps0, 0);
        check("arst_valid0", tv0, 0);
        check("arst_rf0", rf0, 0);
        check("arst_taps1", taps1, 0);
        @(posedge clock);
        #1;
        rst_n  = 1'b1;
        m_col  = 0;
        m_row  = 0;
        m_lw   = ML;
        m_base = 8'h60;
        last0  = '0;
        last1  = '0;
        drive(1'b1, 1'b0, 4);
        check("post_rst_rf", rf0, 1);
        check("post_rst_taps1", taps1, 24'h606060);
        drive(1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
